// File: rtl/led7219_chain.sv
// led7219_chain: refreshes a daisy-chain of NDEV MAX7219 8x8 LED matrices
// from a flat NDEV*64-bit debug vector. Runs the init sequence after reset,
// then refreshes continuously. Supports runtime intensity updates, a
// per-frame snapshot with freeze, and periodic re-initialisation.
module led7219_chain #(
  parameter int NDEV          = 4,
  parameter int CLK_DIV       = 4,
  parameter int INTENSITY     = 8,
  parameter int REINIT_FRAMES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NDEV*64-1:0]   data,
  input  logic                 freeze,
  input  logic [3:0]           intensity,
  input  logic                 intensity_wr,
  output logic                 leds_out,
  output logic                 leds_cs,
  output logic                 leds_clk,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int NBITS = NDEV * 16;
  localparam int DIVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BITW  = $clog2(NBITS);
  localparam int FCW   = (REINIT_FRAMES > 0) ? $clog2(REINIT_FRAMES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LO, S_HI, S_HOLD, S_GAP} state_t;
  typedef enum logic [1:0] {K_INIT, K_INT, K_ROW} kind_t;

  state_t                state_q, state_d;
  logic [DIVW-1:0]       div_q, div_d;
  logic [BITW-1:0]       bit_q, bit_d;
  logic [NBITS-1:0]      sh_q, sh_d;
  kind_t                 kind_q, kind_d;
  logic [2:0]            idx_q, idx_d;
  logic [FCW-1:0]        frm_q, frm_d;
  logic                  pend_q, pend_d;
  logic [3:0]            int_q, int_d;
  logic [NDEV*64-1:0]    snap_q, snap_d;
  logic                  cs_q, sclk_q, busy_q, done_q, done_d;

  logic                  div_last, load, shift, gap_end;
  logic [3:0]            addr;
  logic [7:0]            val, row_byte;
  logic [NBITS-1:0]      word_vec;
  logic [FCW-1:0]        frm_inc;

  assign div_last = (div_q == DIVW'(CLK_DIV - 1));
  assign frm_inc  = frm_q + 1'b1;

  // Transaction engine: CLK_DIV-cycle phases for setup, each bit LO/HI, hold and gap
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    load    = 1'b0;
    shift   = 1'b0;
    gap_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_SETUP;
        div_d   = '0;
        bit_d   = '0;
        load    = 1'b1;
      end
      S_SETUP: begin
        if (div_last) begin
          state_d = S_LO;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LO: begin
        if (div_last) begin
          state_d = S_HI;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HI: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == BITW'(NBITS - 1)) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_LO;
            bit_d   = bit_q + 1'b1;
            shift   = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (div_last) begin
          state_d = S_GAP;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (div_last) begin
          state_d = S_IDLE;
          div_d   = '0;
          gap_end = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer: choose the next transaction when the current gap completes
  always_comb begin
    kind_d = kind_q;
    idx_d  = idx_q;
    frm_d  = frm_q;
    done_d = 1'b0;
    if (gap_end) begin
      case (kind_q)
        K_INIT: begin
          if (idx_q == 3'd4) begin
            kind_d = K_ROW;
            idx_d  = 3'd0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        K_INT: begin
          kind_d = K_ROW;
          idx_d  = 3'd0;
        end
        default: begin
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 1'b1;
          end else begin
            done_d = 1'b1;
            frm_d  = frm_inc;
            idx_d  = 3'd0;
            if ((REINIT_FRAMES != 0) && (frm_inc == FCW'(REINIT_FRAMES))) begin
              frm_d  = '0;
              kind_d = K_INIT;
            end else if (pend_q) begin
              kind_d = K_INT;
            end
          end
        end
      endcase
    end
  end

  // Datapath: snapshot capture, register/value selection and the shift word
  always_comb begin
    snap_d   = snap_q;
    addr     = 4'h0;
    val      = 8'h00;
    row_byte = 8'h00;
    word_vec = '0;
    sh_d     = sh_q;
    if (load && (kind_q == K_ROW) && (idx_q == 3'd0) && !freeze) begin
      snap_d = data;
    end
    case (kind_q)
      K_INIT: begin
        case (idx_q)
          3'd0:    begin addr = 4'hC; val = 8'h01; end
          3'd1:    begin addr = 4'h9; val = 8'h00; end
          3'd2:    begin addr = 4'hB; val = 8'h07; end
          3'd3:    begin addr = 4'hA; val = {4'h0, int_q}; end
          default: begin addr = 4'hF; val = 8'h00; end
        endcase
      end
      K_INT:   begin addr = 4'hA; val = {4'h0, int_q}; end
      default: begin addr = {1'b0, idx_q} + 4'd1; end
    endcase
    for (int d = 0; d < NDEV; d++) begin
      row_byte = snap_d[d*64 + int'(idx_q)*8 +: 8];
      word_vec[d*16 +: 16] = {4'h0, addr, (kind_q == K_ROW) ? row_byte : val};
    end
    if (load) begin
      sh_d = word_vec;
    end else if (shift) begin
      sh_d = {sh_q[NBITS-2:0], 1'b0};
    end
  end

  // Intensity: strobe latches value and sets pending; loading a 0x0A word clears it
  always_comb begin
    pend_d = pend_q;
    int_d  = int_q;
    if (load && (addr == 4'hA)) begin
      pend_d = 1'b0;
    end
    if (intensity_wr) begin
      pend_d = 1'b1;
      int_d  = intensity;
    end
  end

  // Control state and registered pin outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      kind_q  <= K_INIT;
      idx_q   <= 3'd0;
      frm_q   <= '0;
      pend_q  <= 1'b0;
      int_q   <= 4'(INTENSITY);
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      kind_q  <= kind_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      pend_q  <= pend_d;
      int_q   <= int_d;
      cs_q    <= !((state_d == S_SETUP) || (state_d == S_LO) ||
                   (state_d == S_HI) || (state_d == S_HOLD));
      sclk_q  <= (state_d == S_HI);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
    end
  end

  // Frame snapshot holds pixel data only, so it carries no reset
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign leds_out   = sh_q[NBITS-1];
  assign leds_cs    = cs_q;
  assign leds_clk   = sclk_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_led7219_chain.sv
// tb_led7219_chain: directed bench for led7219_chain (NDEV=2, CLK_DIV=2).
// Two instances: dut_a (no early re-init) and dut_b (REINIT_FRAMES=2).
// Serial pins are decoded into 32-bit transaction words and compared with
// hand-built expectations.
module tb_led7219_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rst_b;
  logic [127:0] data_a, data_b;
  logic         freeze_a, freeze_b, wr_a, wr_b;
  logic [3:0]   int_a, int_b;
  logic         out_a, cs_a, sclk_a, busy_a, fd_a;
  logic         out_b, cs_b, sclk_b, busy_b, fd_b;

  led7219_chain #(.NDEV(2), .CLK_DIV(2), .INTENSITY(8), .REINIT_FRAMES(256)) dut_a (
    .clk(clk), .rst(rst), .data(data_a), .freeze(freeze_a), .intensity(int_a),
    .intensity_wr(wr_a), .leds_out(out_a), .leds_cs(cs_a), .leds_clk(sclk_a),
    .busy(busy_a), .frame_done(fd_a));

  led7219_chain #(.NDEV(2), .CLK_DIV(2), .INTENSITY(8), .REINIT_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst_b), .data(data_b), .freeze(freeze_b), .intensity(int_b),
    .intensity_wr(wr_b), .leds_out(out_b), .leds_cs(cs_b), .leds_clk(sclk_b),
    .busy(busy_b), .frame_done(fd_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- serial decoders ----------------
  logic [31:0] qa[$], qb[$], exa[$], exb[$];
  int          lena[$], bitsa[$];
  logic [31:0] acc_a = '0, acc_b = '0;
  int nb_a = 0, low_a = 0, hi_a = 0, sta = 0, hi2_a = 0, fdc_a = 0;
  int nb_b = 0, stb = 0;
  logic pcs_a = 1'b1, pclk_a = 1'b0, pcs_b = 1'b1, pclk_b = 1'b0;

  // Decode dut_a: bits on rising leds_clk, word complete on cs rising
  always @(negedge clk) begin
    if (rst) begin
      acc_a = '0; nb_a = 0; low_a = 0; hi_a = 0; pcs_a = 1'b1; pclk_a = 1'b0;
    end else begin
      if (!cs_a) begin
        if (pcs_a) begin
          sta++;
          if (sta == 2) hi2_a = hi_a;
        end
        low_a++;
        if (sclk_a && !pclk_a) begin
          acc_a = {acc_a[30:0], out_a};
          nb_a++;
        end
      end else begin
        if (!pcs_a) begin
          qa.push_back(acc_a); lena.push_back(low_a); bitsa.push_back(nb_a);
          acc_a = '0; nb_a = 0; low_a = 0; hi_a = 0;
        end
        hi_a++;
      end
      pcs_a = cs_a; pclk_a = sclk_a;
      if (fd_a) fdc_a++;
    end
  end

  // Decode dut_b
  always @(negedge clk) begin
    if (rst_b) begin
      acc_b = '0; nb_b = 0; pcs_b = 1'b1; pclk_b = 1'b0;
    end else begin
      if (!cs_b) begin
        if (pcs_b) stb++;
        if (sclk_b && !pclk_b) begin
          acc_b = {acc_b[30:0], out_b};
          nb_b++;
        end
      end else if (!pcs_b) begin
        qb.push_back(acc_b);
        acc_b = '0; nb_b = 0;
      end
      pcs_b = cs_b; pclk_b = sclk_b;
    end
  end

  // ---------------- expectation helpers ----------------
  function automatic logic [127:0] mkdata(input logic [7:0] hb, input logic [7:0] lb);
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) begin
      v[64 + r*8 +: 8] = hb + 8'(r);
      v[r*8 +: 8]      = lb + 8'(r);
    end
    return v;
  endfunction

  function automatic logic [31:0] roww(input logic [7:0] hb, input logic [7:0] lb, input int r);
    return {8'(r + 1), hb + 8'(r), 8'(r + 1), lb + 8'(r)};
  endfunction

  task automatic add_init(input logic [7:0] iv, input bit to_b);
    logic [31:0] w[5];
    w[0] = 32'h0C010C01; w[1] = 32'h09000900; w[2] = 32'h0B070B07;
    w[3] = {8'h0A, iv, 8'h0A, iv}; w[4] = 32'h0F000F00;
    for (int i = 0; i < 5; i++) begin
      if (to_b) exb.push_back(w[i]); else exa.push_back(w[i]);
    end
  endtask

  task automatic add_frame(input logic [7:0] hb, input logic [7:0] lb, input bit to_b);
    for (int r = 0; r < 8; r++) begin
      if (to_b) exb.push_back(roww(hb, lb, r)); else exa.push_back(roww(hb, lb, r));
    end
  endtask

  task automatic wait_sta(input int n);
    int t = 0;
    while (sta < n && t < 40000) begin @(negedge clk); t++; end
    check_eq($sformatf("wait_sta_%0d", n), 32'(sta >= n), 32'd1);
  endtask

  task automatic wait_qa(input int n);
    int t = 0;
    while (qa.size() < n && t < 40000) begin @(negedge clk); t++; end
    check_eq($sformatf("wait_qa_%0d", n), 32'(qa.size() >= n), 32'd1);
  endtask

  task automatic wait_qb(input int n);
    int t = 0;
    while (qb.size() < n && t < 40000) begin @(negedge clk); t++; end
    check_eq($sformatf("wait_qb_%0d", n), 32'(qb.size() >= n), 32'd1);
  endtask

  // dut_b intensity write during frame 2 row 3, folded into the re-init
  initial begin
    int t = 0;
    int_b = 4'h0; wr_b = 1'b0;
    @(negedge clk);
    while (stb < 16 && t < 40000) begin @(negedge clk); t++; end
    int_b = 4'h5; wr_b = 1'b1;
    @(negedge clk);
    wr_b = 1'b0;
  end

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    rst = 1'b1; rst_b = 1'b1;
    data_a = mkdata(8'h81, 8'h01); data_b = mkdata(8'h81, 8'h01);
    freeze_a = 1'b0; freeze_b = 1'b0; int_a = 4'h0; wr_a = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_cs", 32'(cs_a), 32'd1);
    check_eq("rst_clk", 32'(sclk_a), 32'd0);
    check_eq("rst_out", 32'(out_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_fdone", 32'(fd_a), 32'd0);
    rst = 1'b0; rst_b = 1'b0;
    #1;
    check_eq("rel_busy_low", 32'(busy_a), 32'd0);
    @(negedge clk);
    check_eq("rel_busy_high", 32'(busy_a), 32'd1);
    check_eq("rel_cs_low", 32'(cs_a), 32'd0);

    add_init(8'h08, 1'b0);
    add_frame(8'h81, 8'h01, 1'b0); add_frame(8'h81, 8'h01, 1'b0);
    add_frame(8'hA0, 8'h10, 1'b0); add_frame(8'hA0, 8'h10, 1'b0); add_frame(8'hA0, 8'h10, 1'b0);
    exa.push_back(32'h0A030A03);
    add_frame(8'hC0, 8'h30, 1'b0); add_frame(8'hC0, 8'h30, 1'b0);

    add_init(8'h08, 1'b1);
    add_frame(8'h81, 8'h01, 1'b1); add_frame(8'h81, 8'h01, 1'b1);
    add_init(8'h05, 1'b1);
    add_frame(8'h81, 8'h01, 1'b1); add_frame(8'h81, 8'h01, 1'b1);
    exb.push_back(32'h0C010C01);

    // new data during frame 2 row 4: only visible from frame 3
    wait_sta(17);
    repeat (4) @(negedge clk);
    data_a = mkdata(8'hA0, 8'h10);
    // freeze during frame 3 row 4 with yet another pattern
    wait_sta(25);
    freeze_a = 1'b1;
    data_a = mkdata(8'hC0, 8'h30);
    // intensity write during frame 5 row 2
    wait_sta(39);
    int_a = 4'h3; wr_a = 1'b1;
    @(negedge clk);
    wr_a = 1'b0;
    wait_sta(41);
    freeze_a = 1'b0;

    wait_qa(62);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 62; i++) begin
      if (i < qa.size()) check_eq($sformatf("a_tx%0d", i), qa[i], exa[i]);
    end
    check_eq("cs_low_len", 32'(lena[0]), 32'd132);
    check_eq("bits_per_tx", 32'(bitsa[0]), 32'd32);
    bad = 0;
    for (int i = 0; i < 62; i++) if (lena[i] != 132 || bitsa[i] != 32) bad++;
    check_eq("tx_shape_all", 32'(bad), 32'd0);
    check_eq("cs_high_between", 32'(hi2_a), 32'd3);
    check_eq("frame_done_cycles", 32'(fdc_a), 32'd7);

    // reset during bit 10 of a row transaction
    wait_sta(63);
    begin
      int t = 0;
      while (nb_a < 10 && t < 1000) begin @(negedge clk); t++; end
      check_eq("mid_bit10_reached", 32'(nb_a >= 10), 32'd1);
    end
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_cs", 32'(cs_a), 32'd1);
    check_eq("mid_rst_clk", 32'(sclk_a), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("mid_rst_busy", 32'(busy_a), 32'd0);
    #1;
    rst = 1'b0;
    wait_qa(68);
    for (int i = 0; i < 5; i++) begin
      if (62 + i < qa.size()) check_eq($sformatf("reinit_tx%0d", i), qa[62 + i], exa[i]);
    end
    if (qa.size() > 67) begin
      check_eq("post_rst_bits", 32'(bitsa[62]), 32'd32);
      check_eq("post_rst_row1", qa[67], roww(8'hC0, 8'h30, 0));
    end

    wait_qb(43);
    for (int i = 0; i < 43; i++) begin
      if (i < qb.size()) check_eq($sformatf("b_tx%0d", i), qb[i], exb[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led7219_chain.md
Name: led7219_chain

Overview:
- Parametrised successor of the single-display MAX7219 debug-matrix driver.
- Drives a daisy-chain of NDEV cascaded MAX7219 8x8 LED matrices from a flat NDEV*64-bit debug vector.
- Adds runtime intensity control, a coherent per-frame snapshot with freeze, and periodic re-initialisation for long, noisy debug cables.
- Sits at top level next to the systime/LED logic; pins go to an expansion header.

Parameters:
- NDEV, 4, number of cascaded MAX7219 devices (1..8); data width = NDEV*64.
- CLK_DIV, 4, SPI half-period in clk cycles (>=1).
- INTENSITY, 8, intensity value (0..15) loaded at reset.
- REINIT_FRAMES, 256, frames between automatic re-init sequences; 0 = init only after reset.

Ports:
- clk  in  1  system clock (24 MHz).
- rst  in  1  asynchronous, active-high reset.
- data  in  NDEV*64  pixel vector; device d row r (0..7) = data[d*64+r*8 +: 8]; bit 7 of the byte = column 7.
- freeze  in  1  while high, the snapshot is not refreshed and the last captured frame keeps being displayed.
- intensity  in  4  new intensity value.
- intensity_wr  in  1  one-cycle strobe; latches intensity.
- leds_out  out  1  serial data (DIN of device 0).
- leds_cs  out  1  LOAD/CS, active low.
- leds_clk  out  1  serial clock, idles low.
- busy  out  1  high while any transaction is in progress (cs low or in gap).
- frame_done  out  1  one-cycle pulse after the row-8 transaction's gap completes.

Behaviour:
- Reset (async): leds_cs=1, leds_clk=0, leds_out=0, busy=0, frame_done=0. Pending intensity = INTENSITY. Frame counter = 0. State = INIT.
- Reset mid-transaction aborts immediately; cs goes high with no partial latch sequencing.
- Transaction format:
  - One transaction writes the same register address to all NDEV devices.
  - Shifts NDEV 16-bit words MSB first, each {4'b0, addr[3:0], val[7:0]}.
  - The word for device NDEV-1 is shifted first, device 0 last.
- Transaction timing (state machine):
  - CS_SETUP: cs=0, clk=0, leds_out = first bit; lasts CLK_DIV cycles.
  - Per bit: LO for CLK_DIV cycles (clk=0, data stable), then HI for CLK_DIV cycles (clk=1).
  - leds_out changes only on the HI->LO boundary.
  - After the last HI: CS_HOLD for CLK_DIV cycles (clk=0, cs=0).
  - Then GAP for CLK_DIV cycles (cs=1).
  - Total per transaction = CLK_DIV*(3 + 32*NDEV) cycles.
- Init sequence, in order, all devices:
  - 0x0C=0x01 (normal operation), 0x09=0x00 (no decode), 0x0B=0x07 (scan 8 rows), 0x0A=intensity, 0x0F=0x00 (test off).
  - Then enter FRAME.
- Frame:
  - At the start of the row-1 transaction, the snapshot register captures data unless freeze=1.
  - Transactions for addr 0x01..0x08 carry snapshot row 0..7 respectively.
  - After the row-8 gap: frame_done pulses, the frame counter increments, and the next frame starts immediately (continuous refresh).
- Intensity:
  - intensity_wr latches the value and sets a pending flag.
  - At the next frame boundary, before row 1, one 0x0A transaction is inserted and the flag clears.
  - A strobe arriving while that 0x0A transaction is in progress re-sets the flag (applied at the following boundary).
  - A strobe in the same cycle as flag clear wins: the flag stays set with the new value.
- Re-init: when REINIT_FRAMES!=0 and the counter reaches REINIT_FRAMES at a frame boundary, the counter clears and the full init sequence runs before the next frame. A pending intensity is absorbed into it and the flag clears.
- Frame counter: width clog2(REINIT_FRAMES+1); it never wraps before the compare.
- busy is low only during the single cycle between a GAP end and the next CS_SETUP, and in the first cycle after reset release.

Test Plan:
- NDEV=2, CLK_DIV=2, reset release: decode the first 5 transactions. Each shows 32 bits with words 0x0C01,0x0C01 / 0x0900 x2 / 0x0B07 x2 / 0x0A08 x2 / 0x0F00 x2. Each transaction spans 2*(3+64)=134 cycles, cs low for 132.
- data[127:64]=row bytes 0x81..0x88, data[63:0]=0x01..0x08 (row r at byte r) -> transaction addr r+1 shifts {0x0?, 0x8(r+1)} for device 1 first, then {0x0?, 0x0(r+1)} for device 0. frame_done pulses once per 8 row transactions.
- Change data mid-frame (during row 4) -> rows 5..8 still show the old snapshot; the new values appear from the next frame. freeze=1 across two frames -> the old image is repeated and no capture occurs.
- intensity=0x3 with intensity_wr during row 2 -> exactly one 0x0A03 transaction for all devices, inserted after row 8 and before the next row 1; none in later frames.
- Assert rst during bit 10 of a row transaction -> leds_cs=1 and leds_clk=0 in the same cycle. After release, the init sequence restarts from 0x0C01 with intensity 0x08.
- REINIT_FRAMES=2 -> frames 1,2, then the init sequence (5 transactions), then frame 3. A pending intensity write is folded into the init's 0x0A word with no extra transaction.
